// File: rtl/message_writer_pkg.sv
// message_writer_pkg: sizes, blank code and FSM encoding shared with scroller and LED decoder
package message_writer_pkg;
    localparam int DEPTH  = 16;
    localparam int CHAR_W = 4;
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [CHAR_W-1:0] BLANK_CHAR = 4'hF;
    typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_t;
endpackage

// File: rtl/message_writer.sv
// message_writer: handshake-loaded shadow buffer published one entry per cycle to the display bus
module message_writer
    import message_writer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [CHAR_W-1:0]         wr_char,
    output logic                      wr_ready,
    input  logic                      commit,
    input  logic                      clear,
    output logic [DEPTH*CHAR_W-1:0]   message,
    output logic [PTR_W-1:0]          msg_len,
    output logic                      busy,
    output logic                      overflow
);
    state_t             state, state_nx;
    logic [PTR_W-1:0]   wr_ptr;
    logic [IDX_W-1:0]   copy_idx;
    logic [CHAR_W-1:0]  shadow  [DEPTH];
    logic [CHAR_W-1:0]  display [DEPTH];
    logic               idle, wr_take, last;

    always_comb begin
        idle     = state == IDLE;
        busy     = state == COPY;
        wr_ready = idle && wr_ptr < PTR_W'(DEPTH);
        wr_take  = wr_valid && wr_ready && !clear;
        last     = busy && copy_idx == IDX_W'(DEPTH - 1);
        state_nx = idle ? ((commit && !clear) ? COPY : IDLE) : (last ? IDLE : COPY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i]  <= BLANK_CHAR;
                display[i] <= BLANK_CHAR;
            end
            wr_ptr   <= '0;
            copy_idx <= '0;
            msg_len  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_take) begin
                shadow[wr_ptr[IDX_W-1:0]] <= wr_char;
                wr_ptr                    <= wr_ptr + PTR_W'(1);
            end
            // clear wins over a concurrent write or commit
            if (idle && clear) begin
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else if (idle && wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (busy) begin
                display[copy_idx] <= ({1'b0, copy_idx} < wr_ptr) ? shadow[copy_idx] : BLANK_CHAR;
                copy_idx          <= copy_idx + IDX_W'(1);
            end
            if (last) begin
                msg_len  <= wr_ptr;
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_msg
        assign message[CHAR_W*i +: CHAR_W] = display[i];
    end
endmodule
